// File: rtl/n64_io_pkg.sv
// Shared definitions for the controller-line pad bank: idle line level and a
// constant-evaluable ceiling log2 used to size per-channel counters.
package n64_io_pkg;

  // Controller lines idle high; drive data, synchronisers and the filtered
  // receive level all come out of reset at this level.
  localparam logic IDLE_LEVEL = 1'b1;

  // Smallest r with (1 << r) >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/tribuf_chan.sv
// One pad channel: registered drive controls, input synchroniser, persistence
// filter, post-release receive guard and registered edge pulses.
//
// Handshake: none. The only qualifier is rx_valid_o; rx_fall_o/rx_rise_o are
// single-cycle pulses raised in the same cycle rx_data_o takes its new value,
// and only when rx_valid_o was already 1 for that cycle.
module tribuf_chan
  import n64_io_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4,
  parameter int GUARD_CYCLES = 8,
  parameter bit OPEN_DRAIN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic drv_en_i,
  input  logic drv_data_i,
  input  logic pad_i,
  output logic pad_oe_o,
  output logic pad_out_o,
  output logic rx_data_o,
  output logic rx_valid_o,
  output logic rx_fall_o,
  output logic rx_rise_o
);

  localparam int CW = clog2(FILTER_LEN + 1);
  // A zero-cycle guard still needs a one-bit register to stay legal.
  localparam int GW = (GUARD_CYCLES > 0) ? clog2(GUARD_CYCLES + 1) : 1;

  logic                   en_q, dat_q;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;
  logic                   rx_q, rx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [GW-1:0]          guard_q, guard_d;
  logic                   valid_q, valid_d;
  logic                   fall_q, fall_d;
  logic                   rise_q, rise_d;
  logic                   accept;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Open-drain only ever pulls low and releases for a 1; push-pull drives both.
  assign pad_oe_o  = OPEN_DRAIN ? (en_q & ~dat_q) : en_q;
  assign pad_out_o = OPEN_DRAIN ? 1'b0 : dat_q;

  // Drive controls are registered so the pad changes one edge after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q  <= 1'b0;
      dat_q <= IDLE_LEVEL;
    end else begin
      en_q  <= drv_en_i;
      dat_q <= drv_data_i;
    end
  end

  // Synchroniser shift and persistence filter: a new level is accepted once it
  // has been seen on sync_out for FILTER_LEN consecutive edges.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
    rx_d   = rx_q;
    cnt_d  = '0;
    accept = 1'b0;
    if (sync_out != rx_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        accept = 1'b1;
        rx_d   = sync_out;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Guard reloads on the drive-release edge, aborts if drive returns, else
  // counts down; validity and pulses are judged on the registered state.
  always_comb begin
    guard_d = guard_q;
    if (en_q && !drv_en_i) begin
      guard_d = GW'(GUARD_CYCLES);
    end else if (drv_en_i) begin
      guard_d = '0;
    end else if (guard_q != '0) begin
      guard_d = guard_q - GW'(1);
    end
    valid_d = ~en_q & (guard_q == '0);
    fall_d  = accept & valid_q & ~sync_out;
    rise_d  = accept & valid_q & sync_out;
  end

  // Receive-side state: synchroniser, filter, guard and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{IDLE_LEVEL}};
      rx_q    <= IDLE_LEVEL;
      cnt_q   <= '0;
      guard_q <= '0;
      valid_q <= 1'b0;
      fall_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      guard_q <= guard_d;
      valid_q <= valid_d;
      fall_q  <= fall_d;
      rise_q  <= rise_d;
    end
  end

  assign rx_data_o  = rx_q;
  assign rx_valid_o = valid_q;
  assign rx_fall_o  = fall_q;
  assign rx_rise_o  = rise_q;

endmodule

// File: rtl/tribuf_bank_sync.sv
// Bank of independent bidirectional controller-line pad channels. Each bit of
// the bank is one tribuf_chan; this level only wires channels to their pads.
module tribuf_bank_sync #(
  parameter int CHANNELS     = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4,
  parameter int GUARD_CYCLES = 8,
  parameter bit OPEN_DRAIN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] drv_en,
  input  logic [CHANNELS-1:0] drv_data,
  inout  wire  [CHANNELS-1:0] pad,
  output logic [CHANNELS-1:0] rx_data,
  output logic [CHANNELS-1:0] rx_valid,
  output logic [CHANNELS-1:0] rx_fall,
  output logic [CHANNELS-1:0] rx_rise
);

  logic [CHANNELS-1:0] pad_oe;
  logic [CHANNELS-1:0] pad_out;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    // Released pads float so the line pull-up (or another driver) sets the level.
    assign pad[g] = pad_oe[g] ? pad_out[g] : 1'bz;

    tribuf_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN),
      .GUARD_CYCLES(GUARD_CYCLES),
      .OPEN_DRAIN  (OPEN_DRAIN)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .drv_en_i  (drv_en[g]),
      .drv_data_i(drv_data[g]),
      .pad_i     (pad[g]),
      .pad_oe_o  (pad_oe[g]),
      .pad_out_o (pad_out[g]),
      .rx_data_o (rx_data[g]),
      .rx_valid_o(rx_valid[g]),
      .rx_fall_o (rx_fall[g]),
      .rx_rise_o (rx_rise[g])
    );
  end

endmodule

// File: tb/tb_tribuf_bank_sync.sv
// Directed bench for tribuf_bank_sync: a two-channel open-drain bank on a
// pulled-up bus with an external open-drain driver, plus two single-channel
// banks on pulled-down pads to tell a released pad from a driven 1.
module tb_tribuf_bank_sync;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main bank (CHANNELS=2, defaults) ----------------
  logic [1:0] drv_en, drv_data, ext_low;
  logic [1:0] rx_data, rx_valid, rx_fall, rx_rise;
  wire  [1:0] pad;

  pullup pu0 (pad[0]);
  pullup pu1 (pad[1]);
  for (genvar i = 0; i < 2; i++) begin : g_ext
    assign pad[i] = ext_low[i] ? 1'b0 : 1'bz;
  end

  tribuf_bank_sync #(.CHANNELS(2)) dut (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .pad(pad),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_fall(rx_fall), .rx_rise(rx_rise)
  );

  // ---------------- open-drain bank on a pulled-down pad ----------------
  logic drv_en_od, drv_data_od;
  logic rx_data_od, rx_valid_od, rx_fall_od, rx_rise_od;
  wire  pad_od;
  pulldown pd_od (pad_od);

  tribuf_bank_sync #(.CHANNELS(1), .OPEN_DRAIN(1'b1)) dut_od (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en_od), .drv_data(drv_data_od), .pad(pad_od),
    .rx_data(rx_data_od), .rx_valid(rx_valid_od), .rx_fall(rx_fall_od), .rx_rise(rx_rise_od)
  );

  // ---------------- push-pull, no-guard bank on a pulled-down pad ----------------
  logic drv_en_pp, drv_data_pp;
  logic rx_data_pp, rx_valid_pp, rx_fall_pp, rx_rise_pp;
  wire  pad_pp;
  pulldown pd_pp (pad_pp);

  tribuf_bank_sync #(.CHANNELS(1), .OPEN_DRAIN(1'b0), .GUARD_CYCLES(0)) dut_pp (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en_pp), .drv_data(drv_data_pp), .pad(pad_pp),
    .rx_data(rx_data_pp), .rx_valid(rx_valid_pp), .rx_fall(rx_fall_pp), .rx_rise(rx_rise_pp)
  );

  int n_vec = 0;
  int n_err = 0;

  // One rising edge, then settle to the falling edge where outputs are sampled
  // and new inputs are applied.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drv_en = 2'b11; drv_data = 2'b00; ext_low = 2'b00;
    drv_en_od = 1'b0; drv_data_od = 1'b1; drv_en_pp = 1'b0; drv_data_pp = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (pad !== 2'b11) begin n_err++; $display("FAIL reset_pad: got %b want 11", pad); end
    n_vec++; if (rx_data !== 2'b11) begin n_err++; $display("FAIL reset_rx_data: got %b want 11", rx_data); end
    n_vec++; if (rx_valid !== 2'b00) begin n_err++; $display("FAIL reset_rx_valid: got %b want 00", rx_valid); end
    n_vec++; if ((rx_fall | rx_rise) !== 2'b00) begin n_err++; $display("FAIL reset_pulses: got fall %b rise %b want 00", rx_fall, rx_rise); end
    rst_n = 1'b1; drv_en = 2'b00; drv_data = 2'b11;
    tick();
    n_vec++; if (rx_valid !== 2'b11) begin n_err++; $display("FAIL reset_release_valid: got %b want 11", rx_valid); end
    n_vec++; if (pad !== 2'b11) begin n_err++; $display("FAIL reset_release_pad: got %b want 11", pad); end
  endtask

  task automatic test_receive();
    logic [1:0] exp_fall, exp_rise, exp_data;
    ext_low = 2'b01;
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp_fall = (t == 6) ? 2'b01 : 2'b00;
      exp_data = (t >= 6) ? 2'b10 : 2'b11;
      n_vec++; if (rx_fall !== exp_fall) begin n_err++; $display("FAIL recv_fall t=%0d: got %b want %b", t, rx_fall, exp_fall); end
      n_vec++; if (rx_data !== exp_data) begin n_err++; $display("FAIL recv_data_low t=%0d: got %b want %b", t, rx_data, exp_data); end
      n_vec++; if (rx_rise !== 2'b00) begin n_err++; $display("FAIL recv_no_rise t=%0d: got %b want 00", t, rx_rise); end
    end
    ext_low = 2'b00;
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp_rise = (t == 6) ? 2'b01 : 2'b00;
      exp_data = (t >= 6) ? 2'b11 : 2'b10;
      n_vec++; if (rx_rise !== exp_rise) begin n_err++; $display("FAIL recv_rise t=%0d: got %b want %b", t, rx_rise, exp_rise); end
      n_vec++; if (rx_data !== exp_data) begin n_err++; $display("FAIL recv_data_high t=%0d: got %b want %b", t, rx_data, exp_data); end
      n_vec++; if (rx_fall !== 2'b00) begin n_err++; $display("FAIL recv_no_fall t=%0d: got %b want 00", t, rx_fall); end
    end
  endtask

  task automatic test_glitch();
    int n_fall, n_rise;
    logic saw_low;
    for (int len = 3; len <= 4; len++) begin
      n_fall = 0; n_rise = 0; saw_low = 1'b0;
      ext_low = 2'b01;
      for (int t = 1; t <= 20; t++) begin
        if (t == len + 1) ext_low = 2'b00;
        tick();
        if (rx_fall[0]) n_fall++;
        if (rx_rise[0]) n_rise++;
        if (!rx_data[0]) saw_low = 1'b1;
      end
      n_vec++; if (n_fall !== ((len == 4) ? 1 : 0)) begin n_err++; $display("FAIL glitch_fall len=%0d: got %0d want %0d", len, n_fall, (len == 4) ? 1 : 0); end
      n_vec++; if (n_rise !== ((len == 4) ? 1 : 0)) begin n_err++; $display("FAIL glitch_rise len=%0d: got %0d want %0d", len, n_rise, (len == 4) ? 1 : 0); end
      n_vec++; if (saw_low !== (len == 4)) begin n_err++; $display("FAIL glitch_data len=%0d: saw_low %b want %b", len, saw_low, (len == 4)); end
    end
  endtask

  task automatic test_drive_guard();
    int n_fall, n_rise;
    logic [1:0] exp_valid;
    n_fall = 0; n_rise = 0;
    drv_en = 2'b01; drv_data = 2'b00;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (rx_fall[0]) n_fall++;
      exp_valid = (t == 1) ? 2'b11 : 2'b10;
      n_vec++; if (pad !== 2'b10) begin n_err++; $display("FAIL drive_pad t=%0d: got %b want 10", t, pad); end
      n_vec++; if (rx_valid !== exp_valid) begin n_err++; $display("FAIL drive_valid t=%0d: got %b want %b", t, rx_valid, exp_valid); end
    end
    n_vec++; if (n_fall !== 0) begin n_err++; $display("FAIL drive_no_fall: got %0d want 0", n_fall); end
    n_vec++; if (rx_data !== 2'b10) begin n_err++; $display("FAIL drive_tracks_own: got %b want 10", rx_data); end
    drv_en = 2'b00; drv_data = 2'b11;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (rx_rise[0]) n_rise++;
      exp_valid = (t >= 10) ? 2'b11 : 2'b10;
      n_vec++; if (pad !== 2'b11) begin n_err++; $display("FAIL guard_pad t=%0d: got %b want 11", t, pad); end
      n_vec++; if (rx_valid !== exp_valid) begin n_err++; $display("FAIL guard_valid t=%0d: got %b want %b", t, rx_valid, exp_valid); end
    end
    n_vec++; if (n_rise !== 0) begin n_err++; $display("FAIL guard_no_rise: got %0d want 0", n_rise); end
    n_vec++; if (rx_data !== 2'b11) begin n_err++; $display("FAIL guard_data: got %b want 11", rx_data); end
  endtask

  task automatic test_guard_abort();
    int n_rise;
    logic exp_valid;
    n_rise = 0;
    drv_en = 2'b01; drv_data = 2'b00;
    repeat (10) tick();
    drv_en = 2'b00; drv_data = 2'b11;
    for (int t = 1; t <= 3; t++) begin
      tick();
      n_vec++; if (rx_valid[0] !== 1'b0) begin n_err++; $display("FAIL abort_gap_valid t=%0d: got %b want 0", t, rx_valid[0]); end
      n_vec++; if (pad[0] !== 1'b1) begin n_err++; $display("FAIL abort_gap_pad t=%0d: got %b want 1", t, pad[0]); end
    end
    drv_en = 2'b01; drv_data = 2'b00;
    tick();
    n_vec++; if (pad[0] !== 1'b0) begin n_err++; $display("FAIL abort_redrive_pad: got %b want 0", pad[0]); end
    for (int t = 1; t <= 12; t++) begin
      tick();
      n_vec++; if (rx_valid[0] !== 1'b0) begin n_err++; $display("FAIL abort_hold_valid t=%0d: got %b want 0", t, rx_valid[0]); end
    end
    n_vec++; if (rx_data[0] !== 1'b0) begin n_err++; $display("FAIL abort_gap_filtered: got %b want 0", rx_data[0]); end
    drv_en = 2'b00; drv_data = 2'b11;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (rx_rise[0]) n_rise++;
      exp_valid = (t >= 10);
      n_vec++; if (rx_valid[0] !== exp_valid) begin n_err++; $display("FAIL abort_final_valid t=%0d: got %b want %b", t, rx_valid[0], exp_valid); end
    end
    n_vec++; if (n_rise !== 0) begin n_err++; $display("FAIL abort_no_rise: got %0d want 0", n_rise); end
  endtask

  task automatic test_modes();
    drv_en_od = 1'b1; drv_data_od = 1'b1;
    drv_en_pp = 1'b1; drv_data_pp = 1'b1;
    tick();
    n_vec++; if (pad_od !== 1'b0) begin n_err++; $display("FAIL od_release_one: got %b want 0 (pulled down)", pad_od); end
    n_vec++; if (pad_pp !== 1'b1) begin n_err++; $display("FAIL pp_drive_one: got %b want 1", pad_pp); end
    drv_data_pp = 1'b0;
    tick();
    n_vec++; if (pad_pp !== 1'b0) begin n_err++; $display("FAIL pp_drive_zero: got %b want 0", pad_pp); end
    n_vec++; if (rx_valid_pp !== 1'b0) begin n_err++; $display("FAIL pp_valid_driving: got %b want 0", rx_valid_pp); end
    drv_en_pp = 1'b0; drv_en_od = 1'b0;
    tick();
    n_vec++; if (rx_valid_pp !== 1'b0) begin n_err++; $display("FAIL pp_noguard_edge1: got %b want 0", rx_valid_pp); end
    tick();
    n_vec++; if (rx_valid_pp !== 1'b1) begin n_err++; $display("FAIL pp_noguard_edge2: got %b want 1", rx_valid_pp); end
  endtask

  task automatic test_reset_mid_drive();
    drv_en = 2'b10; drv_data = 2'b00;
    tick();
    tick();
    n_vec++; if (pad[1] !== 1'b0) begin n_err++; $display("FAIL mid_drive_pad: got %b want 0", pad[1]); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (pad[1] !== 1'b1) begin n_err++; $display("FAIL async_release_pad: got %b want 1", pad[1]); end
    n_vec++; if (rx_valid !== 2'b00) begin n_err++; $display("FAIL async_reset_valid: got %b want 00", rx_valid); end
    @(negedge clk);
    rst_n = 1'b1; drv_en = 2'b00; drv_data = 2'b11;
    tick();
    n_vec++; if (rx_valid !== 2'b11) begin n_err++; $display("FAIL rereset_valid: got %b want 11", rx_valid); end
  endtask

  initial begin
    test_reset();
    test_receive();
    test_glitch();
    test_drive_guard();
    test_guard_abort();
    test_modes();
    test_reset_mid_drive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
